id_ex_operand_stage: RTL and testbench
======================================

Name: id_ex_operand_stage

Overview:
ID/EX pipeline stage that sits directly upstream of the ALU operation blocks (add/sub/shift/SRLI wrappers). It registers decoded instruction fields with stall/flush control. It resolves data hazards by forwarding from EX/MEM and MEM/WB, and drives the SrcA, SrcB and Operation operands consumed by the ALU. It also detects load-use hazards and raises a stall request to the hazard unit.

Parameters:
DATA_WIDTH, 32, operand/result width
OPCODE_LENGTH, 4, ALU control code width
REG_ADDR_W, 5, register index width

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low (asserted at 0)
stall  input  1  hold ID/EX contents
flush  input  1  replace ID/EX contents with bubble
id_valid  input  1  ID stage holds a real instruction
id_rd1  input  DATA_WIDTH  rs1 register-file data
id_rd2  input  DATA_WIDTH  rs2 register-file data
id_imm  input  DATA_WIDTH  sign-extended immediate (shamt in [4:0] for shifts)
id_alu_ctrl  input  OPCODE_LENGTH  ALU operation code (e.g. 4'b1010 = SRL)
id_alu_src  input  1  1: SrcB = immediate, 0: SrcB = rs2
id_uses_rs2  input  1  instruction reads rs2 (R-type, store, branch)
id_rs1, id_rs2, id_rd  input  REG_ADDR_W  register indices
id_reg_write, id_mem_read, id_mem_write  input  1  control bits
exmem_rd  input  REG_ADDR_W  EX/MEM destination
exmem_reg_write  input  1  EX/MEM writes register
exmem_result  input  DATA_WIDTH  EX/MEM ALU result
memwb_rd  input  REG_ADDR_W  MEM/WB destination
memwb_reg_write  input  1  MEM/WB writes register
memwb_result  input  DATA_WIDTH  MEM/WB writeback data
ex_valid  output  1  EX holds a real instruction
SrcA  output  DATA_WIDTH  forwarded rs1 operand to ALU
SrcB  output  DATA_WIDTH  immediate or forwarded rs2 operand to ALU
Operation  output  OPCODE_LENGTH  registered ALU control
ex_store_data  output  DATA_WIDTH  forwarded rs2 (store data)
ex_rd  output  REG_ADDR_W  registered destination
ex_reg_write, ex_mem_read, ex_mem_write  output  1  registered control, gated by ex_valid
load_use_stall  output  1  stall request for PC/IF/ID (combinational)

Behaviour:
- Pipeline register update priority: reset > flush > stall > load. Flush with stall simultaneous: bubble inserted.
- Reset (async, reset=0): all registers 0. ex_valid=0, all control bits 0, Operation=0, ex_rd=0, data fields 0. Therefore SrcA=0, SrcB=0, ex_store_data=0, and load_use_stall=0.
- Load: all id_* captured on the rising edge. Latency from ID to EX operands is 1 cycle.
- Bubble (flush): ex_valid=0, ex_reg_write=ex_mem_read=ex_mem_write=0, all other fields cleared to 0.
- Stall: all registers hold their value. Forwarding outputs still track the current exmem/memwb inputs.
- Forward select for each of rs1/rs2 (combinational, from registered indices):
  - EX/MEM if exmem_reg_write and exmem_rd!=0 and exmem_rd==ex_rsN.
  - Otherwise MEM/WB if memwb_reg_write and memwb_rd!=0 and memwb_rd==ex_rsN.
  - Otherwise the registered register-file data.
  - EX/MEM has priority when both match. x0 is never forwarded.
- SrcB = ex_alu_src ? ex_imm : fwd_rs2. ex_store_data = fwd_rs2 always.
- load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_rd!=0) & ((ex_rd==id_rs1) | (id_uses_rs2 & ex_rd==id_rs2)).
  - The hazard unit converts load_use_stall into stall on IF/ID plus flush on this stage.
  - The block does not self-stall.
- Widths: no arithmetic here. Immediate is passed unmodified; the shamt masking is the ALU's job.
- Reset mid-operation: in-flight instruction is discarded with no partial outputs. ex_valid=0 on the first cycle after reset is released.

Decomposition:
- Shared pipeline package holds:
  - ALU operation code constants (ALU_ADD, ALU_SRL=4'b1010, ...).
  - Forward-select enum (FWD_REG, FWD_MEM, FWD_WB).
  - A packed id_ex_t struct of the registered fields.
- One natural sub-module: forwarding_unit. Inputs are ex_rs1, ex_rs2 and the exmem/memwb rd/reg_write signals; outputs are the two forward-select values. It is instantiated once.

Test Plan:
- Reset: drive reset=0 mid-stream with a valid instruction loaded → next sample ex_valid=0, SrcA=0, SrcB=0, Operation=0, load_use_stall=0.
- SRLI pass-through: id_rd1=0x8000_0010, id_imm=4, id_alu_src=1, id_alu_ctrl=4'b1010, no forwarding matches → one cycle later SrcA=0x8000_0010, SrcB=4, Operation=4'b1010, ex_valid=1.
- Forwarding priority: ex_rs1=5, exmem_rd=5 (result 0x11), memwb_rd=5 (result 0x22), both reg_write=1 → SrcA=0x11. Drop exmem_reg_write → SrcA=0x22. Set both rd=0 → SrcA=id_rd1 value.
- Load-use: EX holds lw with rd=7 and ex_mem_read=1; ID has rs2=7 with id_uses_rs2=1 → load_use_stall=1. Repeat with id_uses_rs2=0 and rs1=3 → load_use_stall=0.
- Stall/flush: stall=1 for 3 cycles while id_* change → outputs unchanged. Then stall=1 and flush=1 together → bubble: ex_valid=0, ex_reg_write=0, ex_mem_write=0.
- Store data: id_alu_src=1, id_imm=8, ex_rs2=9, exmem_rd=9 (result 0xABCD) → SrcB=8, ex_store_data=0xABCD.

Source files
------------

// File: rtl/id_ex_operand_stage_pkg.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage_pkg
//   Shared definitions for the ID/EX operand stage:
//     - ALU operation codes driven on Operation toward the ALU blocks
//     - forward-select encoding produced by the forwarding unit
//     - id_ex_t, the packed ID/EX pipeline register contents
//   The struct is sized from the default widths below; the top-level width
//   parameters default to the same values.
// ----------------------------------------------------------------------------
package id_ex_operand_stage_pkg;

   localparam int PKG_DATA_WIDTH    = 32;
   localparam int PKG_OPCODE_LENGTH = 4;
   localparam int PKG_REG_ADDR_W    = 5;

   // ALU control codes
   localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_AND = 4'b0000;
   localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_OR  = 4'b0001;
   localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_ADD = 4'b0010;
   localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_XOR = 4'b0011;
   localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_SLL = 4'b0100;
   localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_SUB = 4'b0110;
   localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_SLT = 4'b0111;
   localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_SRL = 4'b1010;
   localparam logic [PKG_OPCODE_LENGTH-1:0] ALU_SRA = 4'b1011;

   // Operand source chosen for a forwarded register read
   typedef enum logic [1:0] {
      FWD_REG = 2'd0,   // registered register-file data
      FWD_MEM = 2'd1,   // EX/MEM ALU result
      FWD_WB  = 2'd2    // MEM/WB writeback data
   } fwd_sel_t;

   // ID/EX pipeline register contents
   typedef struct packed {
      logic                          valid;
      logic [PKG_OPCODE_LENGTH-1:0]  alu_ctrl;
      logic                          alu_src;
      logic                          reg_write;
      logic                          mem_read;
      logic                          mem_write;
      logic [PKG_REG_ADDR_W-1:0]     rs1;
      logic [PKG_REG_ADDR_W-1:0]     rs2;
      logic [PKG_REG_ADDR_W-1:0]     rd;
      logic [PKG_DATA_WIDTH-1:0]     rd1;
      logic [PKG_DATA_WIDTH-1:0]     rd2;
      logic [PKG_DATA_WIDTH-1:0]     imm;
   } id_ex_t;

endpackage

// File: rtl/id_ex_operand_stage_forwarding_unit.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage_forwarding_unit
//   Chooses the source of each EX-stage register operand. A younger producer
//   (EX/MEM) wins over an older one (MEM/WB); x0 is never forwarded because
//   it is hard-wired to zero in the register file.
//
//   Ports:
//     ex_rs1, ex_rs2          registered source indices of the EX instruction
//     exmem_rd, exmem_reg_write  EX/MEM destination and write enable
//     memwb_rd, memwb_reg_write  MEM/WB destination and write enable
//     fwd_a, fwd_b            forward selects for rs1 / rs2
// ----------------------------------------------------------------------------
module id_ex_operand_stage_forwarding_unit
   import id_ex_operand_stage_pkg::*;
#(
   parameter int REG_ADDR_W = PKG_REG_ADDR_W
) (
   input  logic [REG_ADDR_W-1:0] ex_rs1,
   input  logic [REG_ADDR_W-1:0] ex_rs2,
   input  logic [REG_ADDR_W-1:0] exmem_rd,
   input  logic                  exmem_reg_write,
   input  logic [REG_ADDR_W-1:0] memwb_rd,
   input  logic                  memwb_reg_write,
   output fwd_sel_t              fwd_a,
   output fwd_sel_t              fwd_b
);

   function automatic fwd_sel_t select_src(
      input logic [REG_ADDR_W-1:0] rs,
      input logic [REG_ADDR_W-1:0] mem_rd,
      input logic                  mem_we,
      input logic [REG_ADDR_W-1:0] wb_rd,
      input logic                  wb_we
   );
      fwd_sel_t sel;
      sel = FWD_REG;
      if (mem_we && (mem_rd != '0) && (mem_rd == rs))
         sel = FWD_MEM;
      else if (wb_we && (wb_rd != '0) && (wb_rd == rs))
         sel = FWD_WB;
      return sel;
   endfunction

   always_comb begin
      fwd_a = select_src(ex_rs1, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
      fwd_b = select_src(ex_rs2, exmem_rd, exmem_reg_write, memwb_rd, memwb_reg_write);
   end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ----------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register feeding the ALU operation blocks. Registers the
//   decoded instruction (hold on stall, bubble on flush), forwards EX/MEM and
//   MEM/WB results into the operands, and flags load-use hazards for the
//   hazard unit, which answers with stall on IF/ID plus flush on this stage.
//
//   Ports:
//     clk, reset              rising-edge clock, async active-low reset
//     stall, flush            hold / bubble the ID/EX register (flush wins)
//     id_*                    decoded instruction from ID
//     exmem_*, memwb_*        downstream producers for forwarding
//     ex_valid                EX holds a real instruction
//     SrcA, SrcB, Operation   ALU operands and control
//     ex_store_data           forwarded rs2 for stores
//     ex_rd, ex_reg_write, ex_mem_read, ex_mem_write  registered EX fields
//     load_use_stall          combinational load-use stall request
// ----------------------------------------------------------------------------
module id_ex_operand_stage
   import id_ex_operand_stage_pkg::*;
#(
   parameter int DATA_WIDTH    = PKG_DATA_WIDTH,
   parameter int OPCODE_LENGTH = PKG_OPCODE_LENGTH,
   parameter int REG_ADDR_W    = PKG_REG_ADDR_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stall,
   input  logic                     flush,
   input  logic                     id_valid,
   input  logic [DATA_WIDTH-1:0]    id_rd1,
   input  logic [DATA_WIDTH-1:0]    id_rd2,
   input  logic [DATA_WIDTH-1:0]    id_imm,
   input  logic [OPCODE_LENGTH-1:0] id_alu_ctrl,
   input  logic                     id_alu_src,
   input  logic                     id_uses_rs2,
   input  logic [REG_ADDR_W-1:0]    id_rs1,
   input  logic [REG_ADDR_W-1:0]    id_rs2,
   input  logic [REG_ADDR_W-1:0]    id_rd,
   input  logic                     id_reg_write,
   input  logic                     id_mem_read,
   input  logic                     id_mem_write,
   input  logic [REG_ADDR_W-1:0]    exmem_rd,
   input  logic                     exmem_reg_write,
   input  logic [DATA_WIDTH-1:0]    exmem_result,
   input  logic [REG_ADDR_W-1:0]    memwb_rd,
   input  logic                     memwb_reg_write,
   input  logic [DATA_WIDTH-1:0]    memwb_result,
   output logic                     ex_valid,
   output logic [DATA_WIDTH-1:0]    SrcA,
   output logic [DATA_WIDTH-1:0]    SrcB,
   output logic [OPCODE_LENGTH-1:0] Operation,
   output logic [DATA_WIDTH-1:0]    ex_store_data,
   output logic [REG_ADDR_W-1:0]    ex_rd,
   output logic                     ex_reg_write,
   output logic                     ex_mem_read,
   output logic                     ex_mem_write,
   output logic                     load_use_stall
);

   id_ex_t                  id_p0;
   id_ex_t                  idex_p1;
   logic                    vld_p1;
   fwd_sel_t                fwd_a;
   fwd_sel_t                fwd_b;
   logic [DATA_WIDTH-1:0]   fwd_rs1;
   logic [DATA_WIDTH-1:0]   fwd_rs2;

   // ---- stage p0: ID fields gathered into the register format ----
   always_comb begin
      id_p0           = '0;
      id_p0.valid     = id_valid;
      id_p0.alu_ctrl  = id_alu_ctrl;
      id_p0.alu_src   = id_alu_src;
      id_p0.reg_write = id_reg_write;
      id_p0.mem_read  = id_mem_read;
      id_p0.mem_write = id_mem_write;
      id_p0.rs1       = id_rs1;
      id_p0.rs2       = id_rs2;
      id_p0.rd        = id_rd;
      id_p0.rd1       = id_rd1;
      id_p0.rd2       = id_rd2;
      id_p0.imm       = id_imm;
   end

   // ---- stage p1: ID/EX register (reset > flush > stall > load) ----
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         idex_p1 <= '0;
      else if (flush)
         idex_p1 <= '0;
      else if (!stall)
         idex_p1 <= id_p0;
   end

   assign vld_p1 = idex_p1.valid;

   id_ex_operand_stage_forwarding_unit #(
      .REG_ADDR_W      (REG_ADDR_W)
   ) forwarding_unit (
      .ex_rs1          (idex_p1.rs1),
      .ex_rs2          (idex_p1.rs2),
      .exmem_rd        (exmem_rd),
      .exmem_reg_write (exmem_reg_write),
      .memwb_rd        (memwb_rd),
      .memwb_reg_write (memwb_reg_write),
      .fwd_a           (fwd_a),
      .fwd_b           (fwd_b)
   );

   // Forwarding follows the live exmem/memwb inputs even while stalled.
   always_comb begin
      fwd_rs1 = idex_p1.rd1;
      case (fwd_a)
         FWD_MEM: fwd_rs1 = exmem_result;
         FWD_WB:  fwd_rs1 = memwb_result;
         default: fwd_rs1 = idex_p1.rd1;
      endcase
   end

   always_comb begin
      fwd_rs2 = idex_p1.rd2;
      case (fwd_b)
         FWD_MEM: fwd_rs2 = exmem_result;
         FWD_WB:  fwd_rs2 = memwb_result;
         default: fwd_rs2 = idex_p1.rd2;
      endcase
   end

   assign ex_valid      = vld_p1;
   assign SrcA          = fwd_rs1;
   assign SrcB          = idex_p1.alu_src ? idex_p1.imm : fwd_rs2;
   assign ex_store_data = fwd_rs2;
   assign Operation     = idex_p1.alu_ctrl;
   assign ex_rd         = idex_p1.rd;
   assign ex_reg_write  = vld_p1 & idex_p1.reg_write;
   assign ex_mem_read   = vld_p1 & idex_p1.mem_read;
   assign ex_mem_write  = vld_p1 & idex_p1.mem_write;

   // A load in EX cannot forward its data in time to a dependent ID
   // instruction; rs2 only counts when the instruction actually reads it.
   assign load_use_stall = id_valid & vld_p1 & idex_p1.mem_read &
                           (idex_p1.rd != '0) &
                           ((idex_p1.rd == id_rs1) |
                            (id_uses_rs2 & (idex_p1.rd == id_rs2)));

endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, flush;
   logic        id_valid;
   logic [31:0] id_rd1, id_rd2, id_imm;
   logic [3:0]  id_alu_ctrl;
   logic        id_alu_src, id_uses_rs2;
   logic [4:0]  id_rs1, id_rs2, id_rd;
   logic        id_reg_write, id_mem_read, id_mem_write;
   logic [4:0]  exmem_rd;
   logic        exmem_reg_write;
   logic [31:0] exmem_result;
   logic [4:0]  memwb_rd;
   logic        memwb_reg_write;
   logic [31:0] memwb_result;
   logic        ex_valid;
   logic [31:0] SrcA, SrcB, ex_store_data;
   logic [3:0]  Operation;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write;
   logic        load_use_stall;

   int errors = 0;
   int checks = 0;

   typedef struct {
      string       tag;
      logic        v;
      logic [31:0] a, b, sd;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic        rw, mr, mw, lus;
   } exp_t;

   exp_t exp_q[$];

   id_ex_operand_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush),
      .id_valid(id_valid), .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
      .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_uses_rs2(id_uses_rs2),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
      .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_result(memwb_result),
      .ex_valid(ex_valid), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
      .load_use_stall(load_use_stall)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input string tag, input logic v, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] sd,
                               input logic [3:0] op, input logic [4:0] rd,
                               input logic rw, input logic mr, input logic mw,
                               input logic lus);
      exp_t e;
      e.tag = tag; e.v = v; e.a = a; e.b = b; e.sd = sd; e.op = op;
      e.rd = rd; e.rw = rw; e.mr = mr; e.mw = mw; e.lus = lus;
      return e;
   endfunction

   task automatic push(input exp_t e);
      exp_q.push_back(e);
   endtask

   task automatic compare_out;
      exp_t e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL scoreboard observed=empty expected=entry");
      end else begin
         e = exp_q.pop_front();
         chk({e.tag, ".ex_valid"},       {31'b0, ex_valid},       {31'b0, e.v});
         chk({e.tag, ".SrcA"},           SrcA,                    e.a);
         chk({e.tag, ".SrcB"},           SrcB,                    e.b);
         chk({e.tag, ".ex_store_data"},  ex_store_data,           e.sd);
         chk({e.tag, ".Operation"},      {28'b0, Operation},      {28'b0, e.op});
         chk({e.tag, ".ex_rd"},          {27'b0, ex_rd},          {27'b0, e.rd});
         chk({e.tag, ".ex_reg_write"},   {31'b0, ex_reg_write},   {31'b0, e.rw});
         chk({e.tag, ".ex_mem_read"},    {31'b0, ex_mem_read},    {31'b0, e.mr});
         chk({e.tag, ".ex_mem_write"},   {31'b0, ex_mem_write},   {31'b0, e.mw});
         chk({e.tag, ".load_use_stall"}, {31'b0, load_use_stall}, {31'b0, e.lus});
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [31:0] rd1,
                           input logic [4:0] rs2, input logic [31:0] rd2,
                           input logic [31:0] imm, input logic src, input logic [3:0] ctrl,
                           input logic [4:0] rd, input logic rw, input logic mr,
                           input logic mw, input logic uses2);
      id_valid = v; id_rs1 = rs1; id_rd1 = rd1; id_rs2 = rs2; id_rd2 = rd2;
      id_imm = imm; id_alu_src = src; id_alu_ctrl = ctrl; id_rd = rd;
      id_reg_write = rw; id_mem_read = mr; id_mem_write = mw; id_uses_rs2 = uses2;
   endtask

   task automatic drive_fwd(input logic [4:0] mrd, input logic mwe, input logic [31:0] mres,
                            input logic [4:0] wrd, input logic wwe, input logic [31:0] wres);
      exmem_rd = mrd; exmem_reg_write = mwe; exmem_result = mres;
      memwb_rd = wrd; memwb_reg_write = wwe; memwb_result = wres;
   endtask

   initial begin
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      drive_id(1'b0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 1'b0, 4'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
      tick; tick;
      push(mk("reset", 0, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 0, 0, 0, 0));
      compare_out;
      reset = 1'b1;

      // SRLI pass-through, no forwarding match
      drive_id(1'b1, 5'd1, 32'h8000_0010, 5'd2, 32'h55, 32'd4, 1'b1, 4'b1010, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
      push(mk("srli", 1, 32'h8000_0010, 32'd4, 32'h55, 4'b1010, 5'd3, 1, 0, 0, 0));
      tick;
      compare_out;

      // Forwarding priority on rs1
      drive_id(1'b1, 5'd5, 32'h1234, 5'd6, 32'h66, 32'h0, 1'b0, 4'b0010, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
      drive_fwd(5'd5, 1'b1, 32'h11, 5'd5, 1'b1, 32'h22);
      push(mk("fwd_both", 1, 32'h11, 32'h66, 32'h66, 4'b0010, 5'd10, 1, 0, 0, 0));
      tick;
      compare_out;
      exmem_reg_write = 1'b0;
      #1;
      push(mk("fwd_wb", 1, 32'h22, 32'h66, 32'h66, 4'b0010, 5'd10, 1, 0, 0, 0));
      compare_out;
      drive_fwd(5'd0, 1'b1, 32'h11, 5'd0, 1'b1, 32'h22);
      #1;
      push(mk("fwd_x0", 1, 32'h1234, 32'h66, 32'h66, 4'b0010, 5'd10, 1, 0, 0, 0));
      compare_out;
      drive_fwd(5'd5, 1'b0, 32'h11, 5'd6, 1'b1, 32'h22);
      #1;
      push(mk("fwd_rs2_wb", 1, 32'h1234, 32'h22, 32'h22, 4'b0010, 5'd10, 1, 0, 0, 0));
      compare_out;

      // Load-use detection
      drive_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
      drive_id(1'b1, 5'd1, 32'h100, 5'd0, 32'h0, 32'h10, 1'b1, 4'b0010, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      tick;
      drive_id(1'b1, 5'd4, 32'h0, 5'd7, 32'h0, 32'h0, 1'b0, 4'b0010, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
      #1;
      push(mk("lu_rs2", 1, 32'h100, 32'h10, 32'h0, 4'b0010, 5'd7, 1, 1, 0, 1));
      compare_out;
      id_uses_rs2 = 1'b0; id_rs1 = 5'd3;
      #1;
      push(mk("lu_no_rs2", 1, 32'h100, 32'h10, 32'h0, 4'b0010, 5'd7, 1, 1, 0, 0));
      compare_out;
      id_rs1 = 5'd7;
      #1;
      push(mk("lu_rs1", 1, 32'h100, 32'h10, 32'h0, 4'b0010, 5'd7, 1, 1, 0, 1));
      compare_out;
      id_valid = 1'b0;
      #1;
      push(mk("lu_id_invalid", 1, 32'h100, 32'h10, 32'h0, 4'b0010, 5'd7, 1, 1, 0, 0));
      compare_out;

      // Stall holds EX contents while ID changes
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_id(1'b1, 5'd8, 32'hDEAD_0000 + i, 5'd9, 32'h1000 + i, 32'h3 + i, 1'b0,
                  4'b0110, 5'd12, 1'b0, 1'b0, 1'b1, 1'b1);
         push(mk("stall_hold", 1, 32'h100, 32'h10, 32'h0, 4'b0010, 5'd7, 1, 1, 0, 0));
         tick;
         compare_out;
      end
      flush = 1'b1;
      push(mk("flush_stall", 0, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 0, 0, 0, 0));
      tick;
      compare_out;
      stall = 1'b0; flush = 1'b0;

      // Store data forwarded from EX/MEM while SrcB takes the immediate
      drive_id(1'b1, 5'd2, 32'h200, 5'd9, 32'h999, 32'd8, 1'b1, 4'b0010, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      drive_fwd(5'd9, 1'b1, 32'hABCD, 5'd0, 1'b0, 32'h0);
      push(mk("store", 1, 32'h200, 32'd8, 32'hABCD, 4'b0010, 5'd0, 0, 0, 1, 0));
      tick;
      compare_out;

      // x0 source with x0 destinations downstream: never forwarded
      drive_id(1'b1, 5'd0, 32'h77, 5'd0, 32'h88, 32'h0, 1'b0, 4'b0110, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
      drive_fwd(5'd0, 1'b1, 32'hBAD, 5'd0, 1'b1, 32'hBEE);
      push(mk("x0_src", 1, 32'h77, 32'h88, 32'h88, 4'b0110, 5'd4, 1, 0, 0, 0));
      tick;
      compare_out;

      // Reset mid-operation
      drive_fwd(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0);
      drive_id(1'b1, 5'd11, 32'h5, 5'd12, 32'h6, 32'h0, 1'b0, 4'b1010, 5'd13, 1'b1, 1'b1, 1'b0, 1'b1);
      push(mk("pre_reset", 1, 32'h5, 32'h6, 32'h6, 4'b1010, 5'd13, 1, 1, 0, 0));
      tick;
      compare_out;
      reset = 1'b0;
      #1;
      push(mk("async_reset", 0, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 0, 0, 0, 0));
      compare_out;
      tick;
      reset = 1'b1;
      #1;
      push(mk("after_release", 0, 32'h0, 32'h0, 32'h0, 4'h0, 5'd0, 0, 0, 0, 0));
      compare_out;
      push(mk("reload", 1, 32'h5, 32'h6, 32'h6, 4'b1010, 5'd13, 1, 1, 0, 0));
      tick;
      compare_out;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
